// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one word request at a time, holds the returned
// instruction for the decoder, and squashes in-flight responses on redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        dec_ready,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] pc_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] START_PC   = RESET_PC & ALIGN_MASK;

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic        squash_r, squash_s;
  logic        capture_s;
  logic [31:0] redir_s;
  logic [31:0] instr_r, pc_out_r, addr_r;
  logic        req_r, valid_r;

  assign redir_s = redirect_pc & ALIGN_MASK;

  // Next-state, next-pc and squash decisions; redirect outranks every other event.
  always_comb begin
    state_s   = state_r;
    pc_s      = pc_r;
    squash_s  = squash_r;
    capture_s = 1'b0;
    case (state_r)
      IDLE: begin
        state_s = REQ;
      end
      REQ: begin
        if (redirect_valid) begin
          pc_s = redir_s;
        end else begin
          pc_s = pc_r;
        end
        if (imem_gnt) begin
          state_s  = WAIT;
          // A redirect racing the grant leaves a stale request in flight.
          squash_s = redirect_valid;
        end else begin
          state_s = REQ;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (squash_r || redirect_valid) begin
            state_s  = REQ;
            squash_s = 1'b0;
            pc_s     = redirect_valid ? redir_s : pc_r;
          end else begin
            state_s   = HOLD;
            capture_s = 1'b1;
            pc_s      = pc_r + 32'd4;
          end
        end else begin
          if (redirect_valid) begin
            squash_s = 1'b1;
            pc_s     = redir_s;
          end else begin
            squash_s = squash_r;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_s    = redir_s;
          state_s = REQ;
        end else if (dec_ready) begin
          state_s = REQ;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, pc and registered outputs; outputs are computed from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      pc_r     <= START_PC;
      squash_r <= 1'b0;
      instr_r  <= 32'd0;
      pc_out_r <= 32'd0;
      addr_r   <= 32'd0;
      req_r    <= 1'b0;
      valid_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      pc_r     <= pc_s;
      squash_r <= squash_s;
      addr_r   <= pc_s;
      req_r    <= (state_s == REQ);
      valid_r  <= (state_s == HOLD);
      if (capture_s) begin
        instr_r  <= imem_rdata;
        pc_out_r <= pc_r;
      end else begin
        instr_r  <= instr_r;
        pc_out_r <= pc_out_r;
      end
    end
  end

  assign imem_req    = req_r;
  assign imem_addr   = addr_r;
  assign instr_valid = valid_r;
  assign instr       = instr_r;
  assign opcode      = instr_r[6:0];
  assign funct3      = instr_r[14:12];
  assign funct7      = instr_r[31:25];
  assign pc_out      = pc_out_r;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Parameters
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.

Interface
REQ-002 SHALL have clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have rst_n, input, 1, synchronous active-low reset; one clock, reset synchronous and active-low.
REQ-004 SHALL have imem_req, output, 1, fetch request to instruction memory.
REQ-005 SHALL have imem_addr, output, 32, fetch byte address; bits [1:0] always 0.
REQ-006 SHALL have imem_gnt, input, 1, memory accepts the request this cycle.
REQ-007 SHALL have imem_rvalid, input, 1, read data valid, at least 1 cycle after gnt.
REQ-008 SHALL have imem_rdata, input, 32, instruction word.
REQ-009 SHALL have redirect_valid, input, 1, taken branch/jump/jal from execute.
REQ-010 SHALL have redirect_pc, input, 32, redirect target.
REQ-011 SHALL have dec_ready, input, 1, control unit/decoder consumes the instruction.
REQ-012 SHALL have instr_valid, output, 1, instruction outputs are valid.
REQ-013 SHALL have instr, output, 32; opcode, output, 7 (instr[6:0]); funct3, output, 3 (instr[14:12]); funct7, output, 7 (instr[31:25]); pc_out, output, 32, address of instr.

Function
REQ-014 SHALL implement states IDLE, REQ, WAIT, HOLD, plus a 1-bit squash flag and a 32-bit pc register.
REQ-015 IDLE SHALL last exactly one cycle after reset release, then go to REQ.
REQ-016 In REQ, imem_req=1 and imem_addr=pc; on imem_gnt=1 go to WAIT; otherwise stay in REQ with request and address held stable.
REQ-017 In WAIT with imem_rvalid=1 and squash=0: instr<=imem_rdata, pc_out<=pc, pc<=pc+4 modulo 2^32, go to HOLD.
REQ-018 In WAIT with imem_rvalid=1 and squash=1: discard data, clear squash, go to REQ.
REQ-019 In HOLD, instr_valid=1 and instr/opcode/funct3/funct7/pc_out SHALL stay stable until dec_ready=1; on dec_ready=1 go to REQ.
REQ-020 instr_valid SHALL be 1 only in HOLD; imem_req SHALL be 1 only in REQ.
REQ-021 redirect_valid=1 SHALL load pc<=redirect_pc with bits [1:0] forced to 0, in every state except IDLE.
REQ-022 Redirect in HOLD SHALL drop the held instruction (instr_valid=0 next cycle) and go to REQ; this has priority over dec_ready.
REQ-023 Redirect in REQ without gnt SHALL stay in REQ at the new pc; with gnt the same cycle, go to WAIT with squash=1.
REQ-024 Redirect in WAIT without rvalid SHALL set squash=1; with rvalid the same cycle, discard data and go to REQ.
REQ-025 Redirect in WAIT while squash=1 SHALL keep squash=1 and take the newest redirect_pc.
REQ-026 Minimum throughput SHALL be one instruction per 3 cycles (REQ, WAIT, HOLD) with gnt, rvalid and dec_ready all immediate.

Reset
REQ-027 rst_n=0 at a clock edge SHALL force state=IDLE, pc=RESET_PC, squash=0, instr=0, pc_out=0, imem_req=0, imem_addr=0, instr_valid=0, from any state.
REQ-028 Memory responses arriving after reset, for requests issued before it, SHALL be ignored because the unit is in IDLE or REQ.

Verification
REQ-029 Reset, then gnt and rvalid immediate, rdata=32'h00500093, dec_ready=1 -> imem_addr 0, then instr_valid with opcode 7'h13, funct3 0, pc_out 0; next request addr 4.
REQ-030 HOLD with dec_ready=0 for 5 cycles -> instr and pc_out stable and instr_valid=1 throughout; no imem_req issued.
REQ-031 In WAIT, redirect_valid with redirect_pc=32'h0000_0103, then rvalid with rdata=32'hDEADBEEF -> data dropped, next imem_addr=32'h100, no instr_valid for DEADBEEF.
REQ-032 HOLD with redirect_valid and dec_ready both 1 -> instr_valid=0 next cycle, next fetch at the redirect target.
REQ-033 pc=32'hFFFF_FFFC fetched -> next imem_addr=32'h0000_0000 (wrap).
REQ-034 rst_n=0 asserted in WAIT -> all outputs 0 next cycle; after release, fetch restarts at RESET_PC, and a stale rvalid is ignored.
